// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master req/ack sequencer in front of a single-port data_memory.
// Build option DMEM_ARB_RR_EN selects round-robin tie-break; otherwise m0 always wins a tie.
module dmem_arbiter #(
    parameter int         DEPTH_WORDS = 32,
    parameter logic [2:0] IDLE_CTRL   = 3'b011
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [2:0]  m0_funct3,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [2:0]  m1_funct3,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic [2:0]  mem_read_ctrl,
    output logic [2:0]  mem_write_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        wr_q, wr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef DMEM_ARB_RR_EN
    logic        rr_last_q, rr_last_d;
`endif

    logic        sel_grant;
    logic        sel_wr;
    logic [2:0]  sel_funct3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // A rejected access never reaches the memory, so all checks happen before ACCESS.
    function automatic logic access_err(input logic       wr,
                                        input logic [2:0] funct3,
                                        input logic [31:0] addr);
        logic bad_code;
        logic misaligned;
        logic out_of_range;
        if (wr) bad_code = !(funct3 inside {3'b000, 3'b001, 3'b010});
        else    bad_code = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned   = (funct3[1:0] == 2'b01 && addr[0]) ||
                       (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        out_of_range = addr[31:2] >= DEPTH_LIMIT;
        return bad_code || misaligned || out_of_range;
    endfunction

    // Grant selection: 0 = m0, 1 = m1. Only meaningful when some req is high.
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        if (m0_req && m1_req) sel_grant = ~rr_last_q;
        else                  sel_grant = ~m0_req;
`else
        sel_grant = ~m0_req;
`endif
        sel_wr     = sel_grant ? m1_wr     : m0_wr;
        sel_funct3 = sel_grant ? m1_funct3 : m0_funct3;
        sel_addr   = sel_grant ? m1_addr   : m0_addr;
        sel_wdata  = sel_grant ? m1_wdata  : m0_wdata;
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        wr_d     = wr_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
`ifdef DMEM_ARB_RR_EN
        rr_last_d = rr_last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d  = sel_grant;
                    wr_d     = sel_wr;
                    funct3_d = sel_funct3;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    err_d    = access_err(sel_wr, sel_funct3, sel_addr);
`ifdef DMEM_ARB_RR_EN
                    rr_last_d = sel_grant;
`endif
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rdata_d = (!err_q && !wr_q) ? mem_rdata : 32'h0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory controls decode from registered state, so an async reset idles them at once.
    always_comb begin
        mem_read_ctrl  = IDLE_CTRL;
        mem_write_ctrl = IDLE_CTRL;
        mem_addr       = 32'h0;
        mem_wdata      = 32'h0;
        if (state_q == S_ACCESS && !err_q) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (wr_q) mem_write_ctrl = funct3_q;
            else      mem_read_ctrl  = funct3_q;
        end
    end

    always_comb begin
        m0_ack   = (state_q == S_RESP) && !grant_q;
        m1_ack   = (state_q == S_RESP) &&  grant_q;
        m0_err   = m0_ack && err_q;
        m1_err   = m1_ack && err_q;
        m0_rdata = m0_ack ? rdata_q : 32'h0;
        m1_rdata = m1_ack ? rdata_q : 32'h0;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            wr_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
`ifdef DMEM_ARB_RR_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            wr_q     <= wr_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a byte-array data_memory
// and a transaction-level reference model (memory image + arbitration order).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [2:0]  m0_funct3, m1_funct3;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [2:0]  mem_read_ctrl, mem_write_ctrl;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_funct3(m0_funct3), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_funct3(m1_funct3), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_read_ctrl(mem_read_ctrl), .mem_write_ctrl(mem_write_ctrl),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment: data_memory, little-endian bytes, sync write, combinational read.
    logic [7:0] dmem [0:127];
    logic       mem_clear;
    wire  [6:0] ma = mem_addr[6:0];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 128; i++) dmem[i] <= 8'h00;
        end else begin
            case (mem_write_ctrl)
                3'b000: dmem[ma] <= mem_wdata[7:0];
                3'b001: begin
                    dmem[ma] <= mem_wdata[7:0];
                    dmem[ma + 7'd1] <= mem_wdata[15:8];
                end
                3'b010: begin
                    dmem[ma] <= mem_wdata[7:0];
                    dmem[ma + 7'd1] <= mem_wdata[15:8];
                    dmem[ma + 7'd2] <= mem_wdata[23:16];
                    dmem[ma + 7'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (mem_read_ctrl)
            3'b000:  mem_rdata = {{24{dmem[ma][7]}}, dmem[ma]};
            3'b001:  mem_rdata = {{16{dmem[ma + 7'd1][7]}}, dmem[ma + 7'd1], dmem[ma]};
            3'b010:  mem_rdata = {dmem[ma + 7'd3], dmem[ma + 7'd2], dmem[ma + 7'd1], dmem[ma]};
            3'b100:  mem_rdata = {24'h0, dmem[ma]};
            3'b101:  mem_rdata = {16'h0, dmem[ma + 7'd1], dmem[ma]};
            default: mem_rdata = 32'h0;
        endcase
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: memory image and last granted master.
    logic [7:0] ref_mem [0:127];
    logic       model_last;

    function automatic logic model_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic ok_code;
        int   size;
        ok_code = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size    = 1 << f3[1:0];
        return !ok_code || ((a % 32'(size)) != 0) || (a >= 32'd128);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int          size;
        logic [31:0] v;
        size = 1 << f3[1:0];
        v    = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[7'(a + 32'(i))]) << (8 * i));
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) ref_mem[7'(a + 32'(i))] = d[8 * i +: 8];
    endtask

    task automatic pick(input logic r0, input logic r1, output int w);
        if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            w = (model_last == 1'b1) ? 0 : 1;
`else
            w = 0;
`endif
        end else begin
            w = r0 ? 0 : 1;
        end
        model_last = (w == 1);
    endtask

    task automatic set_fields(input int m, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_wr = wr; m0_funct3 = f3; m0_addr = a; m0_wdata = d;
        end else begin
            m1_wr = wr; m1_funct3 = f3; m1_addr = a; m1_wdata = d;
        end
    endtask

    logic        exp_err [2];
    logic [31:0] exp_rd  [2];
    int          exp_first;
    int          n_exp_wr, n_exp_rd;

    // Issue req on the selected masters (fields already set) and observe 12 cycles.
    task automatic run_txn(input logic use0, input logic use1, input string tag);
        int got [2];
        int acks [2];
        int exp_t [2];
        int wr_act, rd_act, both, stray;
        got = '{-1, -1}; acks = '{0, 0};
        wr_act = 0; rd_act = 0; both = 0; stray = 0;
        if (use0 && use1) begin
            exp_t[exp_first] = 2; exp_t[1 - exp_first] = 5;
        end else begin
            exp_t = '{2, 2};
        end
        m0_req = use0;
        m1_req = use1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_write_ctrl != 3'b011) wr_act++;
            if (mem_read_ctrl != 3'b011) rd_act++;
            if (m0_ack && m1_ack) both++;
            if (!m0_ack && (m0_err || m0_rdata != 0)) stray++;
            if (!m1_ack && (m1_err || m1_rdata != 0)) stray++;
            if (m0_ack) begin
                acks[0]++;
                if (got[0] < 0) begin
                    got[0] = k;
                    check({tag, " m0_err"}, 32'(m0_err), 32'(exp_err[0]));
                    check({tag, " m0_rdata"}, m0_rdata, exp_rd[0]);
                end
                m0_req = 1'b0;
            end
            if (m1_ack) begin
                acks[1]++;
                if (got[1] < 0) begin
                    got[1] = k;
                    check({tag, " m1_err"}, 32'(m1_err), 32'(exp_err[1]));
                    check({tag, " m1_rdata"}, m1_rdata, exp_rd[1]);
                end
                m1_req = 1'b0;
            end
        end
        if (use0) check({tag, " m0_ack_cycle"}, 32'(got[0]), 32'(exp_t[0]));
        if (use1) check({tag, " m1_ack_cycle"}, 32'(got[1]), 32'(exp_t[1]));
        check({tag, " m0_ack_count"}, 32'(acks[0]), use0 ? 32'd1 : 32'd0);
        check({tag, " m1_ack_count"}, 32'(acks[1]), use1 ? 32'd1 : 32'd0);
        check({tag, " write_ctrl_cycles"}, 32'(wr_act), 32'(n_exp_wr));
        check({tag, " read_ctrl_cycles"}, 32'(rd_act), 32'(n_exp_rd));
        check({tag, " both_ack_cycles"}, 32'(both), 32'd0);
        check({tag, " idle_master_outputs"}, 32'(stray), 32'd0);
    endtask

    // Predict one access for master m in model order, updating the image.
    task automatic predict(input int m, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        exp_err[m] = model_err(wr, f3, a);
        exp_rd[m]  = (!exp_err[m] && !wr) ? model_load(f3, a) : 32'h0;
        if (!exp_err[m] && wr) begin
            model_store(f3, a, d);
            n_exp_wr++;
        end
        if (!exp_err[m] && !wr) n_exp_rd++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " m0_ack"}, 32'(m0_ack), 32'd0);
        check({tag, " m1_ack"}, 32'(m1_ack), 32'd0);
        check({tag, " errs"}, 32'({m0_err, m1_err}), 32'd0);
        check({tag, " rdatas"}, m0_rdata | m1_rdata, 32'h0);
        check({tag, " read_ctrl"}, 32'(mem_read_ctrl), 32'd3);
        check({tag, " write_ctrl"}, 32'(mem_write_ctrl), 32'd3);
        check({tag, " mem_addr"}, mem_addr, 32'h0);
    endtask

    typedef struct {
        int          m;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int w;
        int size;
        int ack_seen;
        int order_len;
        int got_order [$];
        int exp_order [$];
        int got_cycle [$];
        int pend0, pend1, m0_served;
        logic        r_wr [2];
        logic [2:0]  r_f3 [2];
        logic [31:0] r_a  [2];
        logic [31:0] r_d  [2];

        //             m  wr    f3      addr          wdata          err   rdata
        vecs.push_back('{0, 1'b1, 3'b010, 32'h08,       32'hDEADBEEF, 1'b0, 32'h00000000});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h08,       32'h0,        1'b0, 32'hDEADBEEF});
        vecs.push_back('{0, 1'b1, 3'b000, 32'h05,       32'h000000AB, 1'b0, 32'h00000000});
        vecs.push_back('{0, 1'b0, 3'b100, 32'h05,       32'h0,        1'b0, 32'h000000AB});
        vecs.push_back('{0, 1'b0, 3'b000, 32'h05,       32'h0,        1'b0, 32'hFFFFFFAB});
        vecs.push_back('{0, 1'b1, 3'b001, 32'h06,       32'h00008001, 1'b0, 32'h00000000});
        vecs.push_back('{0, 1'b0, 3'b101, 32'h06,       32'h0,        1'b0, 32'h00008001});
        vecs.push_back('{0, 1'b0, 3'b001, 32'h06,       32'h0,        1'b0, 32'hFFFF8001});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h04,       32'h0,        1'b0, 32'h8001AB00});
        vecs.push_back('{1, 1'b0, 3'b001, 32'h03,       32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h80,       32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{0, 1'b1, 3'b010, 32'h7C,       32'h12345678, 1'b0, 32'h00000000});
        vecs.push_back('{1, 1'b0, 3'b010, 32'h7C,       32'h0,        1'b0, 32'h12345678});
        vecs.push_back('{1, 1'b0, 3'b000, 32'h09,       32'h0,        1'b0, 32'hFFFFFFBE});
        vecs.push_back('{0, 1'b0, 3'b101, 32'h0A,       32'h0,        1'b0, 32'h0000DEAD});
        vecs.push_back('{0, 1'b1, 3'b010, 32'h02,       32'h11111111, 1'b1, 32'h00000000});
        vecs.push_back('{0, 1'b1, 3'b100, 32'h00,       32'h22222222, 1'b1, 32'h00000000});
        vecs.push_back('{1, 1'b0, 3'b011, 32'h00,       32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{0, 1'b1, 3'b001, 32'h05,       32'h00003333, 1'b1, 32'h00000000});
        vecs.push_back('{0, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{1, 1'b1, 3'b000, 32'h7F,       32'h00000077, 1'b0, 32'h00000000});
        vecs.push_back('{1, 1'b0, 3'b100, 32'h7F,       32'h0,        1'b0, 32'h00000077});

        rst = 1'b1; mem_clear = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;
        set_fields(0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_fields(1, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        model_last = 1'b1;
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0; mem_clear = 1'b0;

        // Directed table: single-master accesses with hand-derived results.
        foreach (vecs[i]) begin
            set_fields(vecs[i].m, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            pick(vecs[i].m == 0, vecs[i].m == 1, w);
            n_exp_wr = 0; n_exp_rd = 0;
            if (!vecs[i].exp_err && vecs[i].wr) n_exp_wr = 1;
            if (!vecs[i].exp_err && !vecs[i].wr) n_exp_rd = 1;
            exp_err[vecs[i].m] = vecs[i].exp_err;
            exp_rd[vecs[i].m]  = vecs[i].exp_rdata;
            if (!model_err(vecs[i].wr, vecs[i].f3, vecs[i].addr) && vecs[i].wr)
                model_store(vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            exp_first = vecs[i].m;
            run_txn(vecs[i].m == 0, vecs[i].m == 1, $sformatf("vec%0d", i));
        end

        // Reset during the ACCESS cycle of a byte store: the write must be dropped.
        set_fields(0, 1'b1, 3'b000, 32'h05, 32'h0000005C);
        m0_req = 1'b1;
        @(negedge clk);
        check("rst_access write_ctrl_before", 32'(mem_write_ctrl), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_access");
        m0_req = 1'b0;
        ack_seen = 0;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) ack_seen++;
        end
        check("rst_access acks_after", 32'(ack_seen), 32'd0);
        set_fields(0, 1'b0, 3'b100, 32'h05, 32'h0);
        pick(1'b1, 1'b0, w);
        n_exp_wr = 0; n_exp_rd = 0;
        predict(0, 1'b0, 3'b100, 32'h05, 32'h0);
        check("rst_access old_byte_model", exp_rd[0], 32'h000000AB);
        run_txn(1'b1, 1'b0, "rst_access lbu");

        // Idle reset pulse, then the contention sequence starts from rr_last=1.
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_idle");
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;

        pend0 = 2; pend1 = 1;
        while (pend0 + pend1 > 0) begin
            pick(pend0 > 0, pend1 > 0, w);
            exp_order.push_back(w);
            if (w == 0) pend0--; else pend1--;
        end
        set_fields(0, 1'b0, 3'b010, 32'h08, 32'h0);
        set_fields(1, 1'b0, 3'b010, 32'h7C, 32'h0);
        m0_req = 1'b1; m1_req = 1'b1;
        m0_served = 0;
        ack_seen = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (m0_ack && m1_ack) ack_seen++;
            if (m0_ack) begin
                got_order.push_back(0);
                got_cycle.push_back(k);
                check("contend m0_rdata", m0_rdata, model_load(m0_funct3, m0_addr));
                m0_served++;
                if (m0_served == 1) set_fields(0, 1'b0, 3'b100, 32'h05, 32'h0);
                else m0_req = 1'b0;
            end
            if (m1_ack) begin
                got_order.push_back(1);
                got_cycle.push_back(k);
                check("contend m1_rdata", m1_rdata, model_load(m1_funct3, m1_addr));
                m1_req = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("contend both_ack_cycles", 32'(ack_seen), 32'd0);
        check("contend grant_count", 32'(got_order.size()), 32'(exp_order.size()));
        order_len = (got_order.size() < exp_order.size()) ? got_order.size() : exp_order.size();
        for (int i = 0; i < order_len; i++) begin
            check($sformatf("contend grant%0d", i), 32'(got_order[i]), 32'(exp_order[i]));
            check($sformatf("contend ack_cycle%0d", i), 32'(got_cycle[i]), 32'(2 + 3 * i));
        end

        // Randomized traffic against the reference model.
        for (int it = 0; it < 80; it++) begin
            int mask;
            mask = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++) begin
                r_wr[m] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) begin
                    r_f3[m] = 3'($urandom_range(0, 7));
                end else if (r_wr[m]) begin
                    r_f3[m] = 3'($urandom_range(0, 2));
                end else begin
                    case ($urandom_range(0, 4))
                        0: r_f3[m] = 3'b000;
                        1: r_f3[m] = 3'b001;
                        2: r_f3[m] = 3'b010;
                        3: r_f3[m] = 3'b100;
                        default: r_f3[m] = 3'b101;
                    endcase
                end
                size = 1 << r_f3[m][1:0];
                case ($urandom_range(0, 9))
                    0: r_a[m] = $urandom;
                    1: r_a[m] = 32'($urandom_range(0, 127));
                    default: r_a[m] = 32'($urandom_range(0, 127)) & ~32'(size - 1);
                endcase
                r_d[m] = $urandom;
                set_fields(m, r_wr[m], r_f3[m], r_a[m], r_d[m]);
            end
            pick(mask[0], mask[1], w);
            exp_first = w;
            n_exp_wr = 0; n_exp_rd = 0;
            predict(w, r_wr[w], r_f3[w], r_a[w], r_d[w]);
            if (mask == 3) predict(1 - w, r_wr[1 - w], r_f3[1 - w], r_a[1 - w], r_d[1 - w]);
            run_txn(mask[0], mask[1], $sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
